key_debounce8: RTL and testbench

Eight-channel key debouncer that sits directly upstream of the 8-to-3 priority encoder. It takes eight raw, asynchronous, active-low key inputs and synchronises and debounces each one. It drives clean active-low levels straight into the encoder's `iData` port and the encoder enable into its `iEI` port. It also produces one-cycle press and release event pulses for downstream control logic.

---
 rtl/key_pkg.sv | 17 +
 rtl/debounce_ch.sv | 51 +++++
 rtl/key_debounce8.sv | 55 +++++
 tb/tb_key_debounce8.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants for the eight-channel key debouncer feeding the 8-to-3 priority encoder.
// Keys are active-low, so the released level of every channel is 1.
package key_pkg;

   localparam int             NUM_KEYS   = 8;
   localparam logic [7:0]     KEY_IDLE   = 8'hFF;
   localparam int             STABLE_DEF = 50000;   // 1 ms at 50 MHz
   localparam int             CNT_W_DEF  = 16;

   // Per-channel view gathered by the top level before reduction.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } ch_status_t;

endpackage

// File: rtl/debounce_ch.sv
// One key channel: two-flop synchroniser, stability counter and accepted level.
// rise/fall are combinational strobes that are high in the cycle before the level changes.
module debounce_ch
   import key_pkg::*;
#(
   parameter int STABLE = STABLE_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic rise,
   output logic fall
);

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;
   logic             done;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

   // The count only advances while s2 differs, so hitting CNT_LAST with s2 still
   // differing means STABLE consecutive differing samples have been seen.
   assign done = (s2 != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= KEY_IDLE[0];
         s2    <= KEY_IDLE[0];
         cnt   <= '0;
         level <= KEY_IDLE[0];
      end else begin
         s1 <= key_n;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (done) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign fall = done &  level;
   assign rise = done & ~level;

endmodule

// File: rtl/key_debounce8.sv
// Eight independent debounce channels plus registered press/release event pulses
// and the registered encoder enable (active-low) for the downstream priority encoder.
module key_debounce8
   import key_pkg::*;
#(
   parameter int STABLE = STABLE_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic [NUM_KEYS-1:0] iKeyN,
   input  logic                iEn,
   output logic [NUM_KEYS-1:0] oKeyN,
   output logic                oEI,
   output logic                oPress,
   output logic                oRelease
);

   ch_status_t [NUM_KEYS-1:0] st;
   logic       [NUM_KEYS-1:0] rise;
   logic       [NUM_KEYS-1:0] fall;

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      debounce_ch #(
         .STABLE (STABLE),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk   (iClk),
         .rst   (iRst),
         .key_n (iKeyN[g]),
         .level (st[g].level),
         .rise  (st[g].rise),
         .fall  (st[g].fall)
      );

      assign oKeyN[g] = st[g].level;
      assign rise[g]  = st[g].rise;
      assign fall[g]  = st[g].fall;
   end

   // Strobes lead the level change by one cycle; registering them lines the
   // pulses up with the first cycle the new oKeyN is visible.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oEI      <= 1'b1;
         oPress   <= 1'b0;
         oRelease <= 1'b0;
      end else begin
         oEI      <= ~iEn;
         oPress   <= |fall;
         oRelease <= |rise;
      end
   end

endmodule

// File: tb/tb_key_debounce8.sv
// Self-checking bench for key_debounce8 (STABLE=4, CNT_W=3): a history-window
// reference model pushes expected outputs each edge; the negedge sampler pops and compares.
module tb_key_debounce8;

   localparam int ST = 4;

   logic       iClk;
   logic       iRst;
   logic [7:0] iKeyN;
   logic       iEn;
   logic [7:0] oKeyN;
   logic       oEI;
   logic       oPress;
   logic       oRelease;

   int checks = 0;
   int errors = 0;
   int np = 0;
   int nr = 0;
   int nboth = 0;
   int n;

   logic [10:0] sb[$];
   logic [7:0]  hist [0:ST+1];
   logic [7:0]  m_lvl;
   logic        m_ei;
   logic        m_pr;
   logic        m_rl;

   key_debounce8 #(.STABLE(ST), .CNT_W(3)) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iKeyN    (iKeyN),
      .iEn      (iEn),
      .oKeyN    (oKeyN),
      .oEI      (oEI),
      .oPress   (oPress),
      .oRelease (oRelease)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   // Highest-index pressed (0) bit, as the downstream priority encoder reports it.
   function automatic logic [2:0] enc(input logic [7:0] d);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (!d[i]) r = 3'(i);
      return r;
   endfunction

   // A bit is accepted when the last ST synchronised samples (raw delayed by two
   // edges) all agree and differ from the currently accepted level.
   always @(posedge iClk) begin
      logic [7:0] nxt;
      logic       same;
      if (iRst) begin
         for (int i = 0; i < ST + 2; i++) hist[i] = 8'hFF;
         m_lvl = 8'hFF;
         m_ei  = 1'b1;
         m_pr  = 1'b0;
         m_rl  = 1'b0;
      end else begin
         for (int i = ST + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = iKeyN;
         nxt = m_lvl;
         for (int b = 0; b < 8; b++) begin
            same = 1'b1;
            for (int j = 3; j <= ST + 1; j++) if (hist[j][b] != hist[2][b]) same = 1'b0;
            if (same && hist[2][b] != m_lvl[b]) nxt[b] = hist[2][b];
         end
         m_pr  = |(m_lvl & ~nxt);
         m_rl  = |(~m_lvl & nxt);
         m_lvl = nxt;
         m_ei  = ~iEn;
      end
      sb.push_back({m_lvl, m_ei, m_pr, m_rl});
   end

   always @(negedge iClk) begin
      logic [10:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("cycle", {21'd0, oKeyN, oEI, oPress, oRelease}, {21'd0, e});
      end
      if (oPress === 1'b1) np++;
      if (oRelease === 1'b1) nr++;
      if (oPress === 1'b1 && oRelease === 1'b1) nboth++;
   end

   // Edges until oKeyN reaches v (bounded), then realign to the falling edge.
   task automatic wait_lvl(input logic [7:0] v, output int cnt);
      cnt = 0;
      while (oKeyN !== v && cnt < 20) begin
         @(posedge iClk);
         #1;
         cnt++;
      end
      @(negedge iClk);
   endtask

   initial begin
      iRst  = 1'b1;
      iKeyN = 8'h00;
      iEn   = 1'b0;
      repeat (3) @(negedge iClk);
      chk("rst_key", oKeyN, 8'hFF);
      chk("rst_ei", oEI, 1);
      chk("rst_pulse", {oPress, oRelease}, 0);
      iKeyN = 8'hFF;
      iRst  = 1'b0;
      repeat (20) @(negedge iClk);
      chk("idle_key", oKeyN, 8'hFF);

      // clean press / release
      np = 0; nr = 0;
      iKeyN = 8'hFE;
      wait_lvl(8'hFE, n);
      chk("press_lat", n, 6);
      repeat (3) @(negedge iClk);
      chk("press_cnt", np, 1);
      iKeyN = 8'hFF;
      wait_lvl(8'hFF, n);
      chk("rel_lat", n, 6);
      repeat (3) @(negedge iClk);
      chk("rel_cnt", nr, 1);

      // bounce on bit 3
      np = 0; nr = 0;
      iKeyN = 8'hF7; repeat (3) @(negedge iClk);
      iKeyN = 8'hFF; repeat (1) @(negedge iClk);
      iKeyN = 8'hF7; repeat (2) @(negedge iClk);
      iKeyN = 8'hFF; repeat (12) @(negedge iClk);
      chk("bounce_key", oKeyN, 8'hFF);
      chk("bounce_pulse", np + nr, 0);
      iKeyN = 8'hF7;
      wait_lvl(8'hF7, n);
      chk("bounce_lat", n, 6);
      repeat (4) @(negedge iClk);
      iKeyN = 8'hFF;
      wait_lvl(8'hFF, n);
      repeat (2) @(negedge iClk);

      // simultaneous press and release
      iKeyN = 8'h7F;
      wait_lvl(8'h7F, n);
      repeat (2) @(negedge iClk);
      np = 0; nr = 0; nboth = 0;
      iKeyN = 8'hBF;
      wait_lvl(8'hBF, n);
      chk("simul_lat", n, 6);
      repeat (2) @(negedge iClk);
      chk("simul_both", nboth, 1);
      chk("simul_np", np, 1);
      chk("simul_nr", nr, 1);
      iKeyN = 8'hFF;
      wait_lvl(8'hFF, n);
      repeat (2) @(negedge iClk);

      // reset at the third edge of a pending press
      iKeyN = 8'hFE;
      @(negedge iClk);
      @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      chk("midrst_key", oKeyN, 8'hFF);
      wait_lvl(8'hFE, n);
      chk("midrst_lat", n, 6);
      repeat (2) @(negedge iClk);

      // encoder hookup
      iEn   = 1'b1;
      iKeyN = 8'hDB;
      wait_lvl(8'hDB, n);
      chk("enc_lat", n, 6);
      chk("enc_data", oKeyN, 8'hDB);
      chk("enc_ei", oEI, 0);
      chk("enc_out", enc(oKeyN), 5);
      repeat (3) @(negedge iClk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
